m68k_bus_decoder: RTL

Parametrised, registered successor to the per-PCB combinational chip-select logic. It decodes 68000 bus cycles against a table of base/mask regions and drives one-hot chip selects. It also generates DTACK with per-region wait states and optional external stretch, and reports the matched region index. It sits between the 68000 core and all M68K-side peripherals, and replaces hand-written per-board select lists for new Toaplan-class boards.

---
 rtl/m68k_bus_decoder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/m68k_bus_decoder.sv
// 68000 bus-cycle decoder: base/mask region table, registered one-hot chip selects,
// DTACK with per-region wait states and ext_wait stretch. Optional macro: BUS_TIMEOUT_EN.
module m68k_bus_decoder #(
  parameter int                              NUM_REGIONS = 8,
  parameter int                              ADDR_W      = 24,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_MASK = '0,
  parameter logic [NUM_REGIONS*4-1:0]        REGION_WAIT = '0,
  parameter int                              TIMEOUT     = 64,
  localparam int                             IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      cpu_a,
  input  logic                   cpu_as_n,
  input  logic                   cpu_rw,
  input  logic [NUM_REGIONS-1:0] ext_wait,
  output logic [NUM_REGIONS-1:0] cs,
  output logic                   cs_any,
  output logic [IDX_W-1:0]       region_idx,
  output logic                   rw_q,
  output logic                   cpu_dtack_n,
  output logic                   cpu_berr_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACK,
    S_BERR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                   r_as_n_d;
  logic                   r_armed;
  logic                   r_hit;
  logic [IDX_W-1:0]       r_idx;
  logic [3:0]             r_cnt;
  logic                   r_rw_q;
  logic [NUM_REGIONS-1:0] r_cs;
  logic [IDX_W-1:0]       r_region_idx;
  logic                   r_dtack_n;
  logic                   r_berr_n;

  logic                   w_start;
  logic                   w_hit;
  logic [IDX_W-1:0]       w_idx;
  logic [3:0]             w_wait;
  logic [NUM_REGIONS-1:0] w_oh;
  logic                   w_ext;
  logic                   w_cnt_zero;
  logic                   w_ackable;
  logic                   w_tmo_hit;
  logic [NUM_REGIONS-1:0] w_cs_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   w_dtack_n_nxt;
  logic                   w_berr_n_nxt;

  // r_armed blocks a cycle start after reset until AS has been seen high once.
  assign w_start    = r_armed & r_as_n_d & ~cpu_as_n;
  assign w_cnt_zero = (r_cnt == 4'd0);
  assign w_ext      = r_hit & ext_wait[r_idx];

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo;

  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_ackable = r_hit;
`else
  assign w_tmo_hit = 1'b0;
  assign w_ackable = 1'b1;
`endif

  // NOTE: in always_comb, assign every output a default first so no latch is inferred;
  // the descending loop with blocking assignments lets the lowest matching index win.
  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_wait = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((cpu_a & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        w_hit  = 1'b1;
        w_idx  = IDX_W'(i);
        w_wait = REGION_WAIT[i*4 +: 4];
      end
    end
  end

  always_comb begin
    w_oh = '0;
    if (r_hit) w_oh[r_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (cpu_as_n)       w_state_nxt = S_IDLE;
        else if (w_tmo_hit) w_state_nxt = S_BERR;
        else                w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cpu_as_n)                                w_state_nxt = S_IDLE;
        else if (w_cnt_zero && !w_ext && w_ackable)  w_state_nxt = S_ACK;
        else if (w_tmo_hit)                          w_state_nxt = S_BERR;
      end
      S_ACK:    if (cpu_as_n) w_state_nxt = S_IDLE;
      S_BERR:   if (cpu_as_n) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they change on the same edge as the FSM.
  always_comb begin
    w_cs_nxt      = '0;
    w_idx_nxt     = r_region_idx;
    w_dtack_n_nxt = 1'b1;
    w_berr_n_nxt  = 1'b1;
    if (w_state_nxt == S_WAIT || w_state_nxt == S_ACK) begin
      w_cs_nxt = w_oh;
      if (r_hit) w_idx_nxt = r_idx;
    end
    if (w_state_nxt == S_ACK)  w_dtack_n_nxt = 1'b0;
    if (w_state_nxt == S_BERR) w_berr_n_nxt  = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_as_n_d     <= 1'b1;
      r_armed      <= 1'b0;
      r_hit        <= 1'b0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_rw_q       <= 1'b1;
      r_cs         <= '0;
      r_region_idx <= '0;
      r_dtack_n    <= 1'b1;
      r_berr_n     <= 1'b1;
    end else begin
      r_as_n_d <= cpu_as_n;
      if (cpu_as_n) r_armed <= 1'b1;

      // Unmatched accesses load wait 0 and acknowledge as open bus.
      if (r_state == S_IDLE && w_start) begin
        r_hit  <= w_hit;
        r_idx  <= w_idx;
        r_cnt  <= w_hit ? w_wait : 4'd0;
        r_rw_q <= cpu_rw;
      end else if (r_state == S_WAIT && !w_cnt_zero) begin
        r_cnt <= r_cnt - 4'd1;
      end

      r_cs         <= w_cs_nxt;
      r_region_idx <= w_idx_nxt;
      r_dtack_n    <= w_dtack_n_nxt;
      r_berr_n     <= w_berr_n_nxt;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Saturating count of cycles since the AS edge; reaching TIMEOUT forces BERR.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (r_state == S_IDLE && w_start) begin
      r_tmo <= '0;
    end else if (r_state != S_IDLE && r_tmo != TMO_W'(TIMEOUT)) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`endif

  assign cs          = r_cs;
  assign cs_any      = |r_cs;
  assign region_idx  = r_region_idx;
  assign rw_q        = r_rw_q;
  assign cpu_dtack_n = r_dtack_n;
`ifdef BUS_TIMEOUT_EN
  assign cpu_berr_n  = r_berr_n;
`else
  assign cpu_berr_n  = 1'b1;
`endif

endmodule
